symbol_packer: RTL
==================

// Module: symbol_packer
// PURPOSE
//  Downstream consumer of the FIFO decoder output stream. The decoder presents each DW-bit symbol
//  for REP consecutive enabled cycles. This block samples each symbol exactly once and packs PACK
//  consecutive symbols into one word. Finished words go through a DEPTH-entry output queue with a
//  valid/ready handshake. Overrun (queue full) drops the word and raises a sticky flag.
// PARAMETERS
//  DW     4   symbol width (matches decoder DW)
//  PACK   4   symbols per output word; output width is DW*PACK
//  REP    2   enabled cycles each upstream symbol is held (>=1)
//  DEPTH  2   output queue entries (power of 2, >=2)
// PORTS
//  CLK        in   1         clock, rising edge
//  RST        in   1         asynchronous reset, active-high
//  EN         in   1         stream enable (same enable that drives the decoder)
//  DIN        in   DW        symbol from decoder DOUT
//  OUT_READY  in   1         consumer accepts head word this cycle
//  OUT_VALID  out  1         queue non-empty
//  DOUT       out  DW*PACK   head word; 0 when queue empty
//  OVERFLOW   out  1         sticky: a completed word was dropped
//  WORD_CNT   out  8         count of words accepted into queue, wraps 255->0
// BEHAVIOUR
//  Reset (RST=1, async): phase=0, lane=0, partial word=0, queue empty (rd=wr=0), OUT_VALID=0,
//   DOUT=0, OVERFLOW=0, WORD_CNT=0. All state clears immediately, including mid-word and mid-handshake.
//  Phase counter: counts 0..REP-1 on each EN=1 cycle and wraps to 0. EN=0 forces phase=0.
//   Phase 0 is the first EN=1 cycle of each symbol.
//  Sample: on an EN=1 cycle with phase==REP-1, DIN is written to partial[lane*DW +: DW].
//   Lane 0 is the LSBs. lane then increments.
//  Word complete: when a sample occurs with lane==PACK-1, the completed word is pushed and lane returns to 0.
//   The pushed word is {DIN, partial[(PACK-1)*DW-1:0]}.
//   The partial register clears to 0 on push.
//  EN=0: phase, lane and partial clear to 0, so any incomplete word is discarded. The queue, OVERFLOW and
//   WORD_CNT are held. The output handshake keeps operating while EN=0.
//  Queue: pointers are AW+1 bits wide (AW=$clog2(DEPTH)), with the MSB used as the wrap bit.
//   empty = (rd==wr); full = (low bits equal and MSBs differ).
//  Pop: occurs when OUT_VALID && OUT_READY at the clock edge; rd advances.
//  Push: accepted if the queue is not full, or if a pop occurs in the same cycle.
//   An accepted push advances wr and increments WORD_CNT.
//  Push while full with no pop: the word is dropped. OVERFLOW is set to 1 and stays 1 until RST.
//   WORD_CNT does not increment and the queue contents are unchanged.
//  Simultaneous push and pop while empty is impossible, because OUT_VALID=0 means no pop can occur.
//   The pushed word becomes visible the next cycle.
//  Latency: the word becomes visible on OUT_VALID/DOUT one cycle after the edge that samples its last symbol.
//   With REP=2 and PACK=4, the first word appears 8 enabled cycles after EN rises.
//  OUT_READY while OUT_VALID=0 has no effect.
//  DOUT stays stable while OUT_VALID=1 and OUT_READY=0.
// TESTING (DW=4, PACK=4, REP=2, DEPTH=2)
//  1 Basic pack: EN=1, DIN=1,2,3,4, each held 2 cycles, OUT_READY=1.
//    -> OUT_VALID=1 for 1 cycle with DOUT=16'h4321, WORD_CNT=1, OVERFLOW=0.
//  2 Backpressure: OUT_READY=0, stream words 16'h4321, 16'h8765, 16'hCBA9.
//    -> queue holds the first two words, the third is dropped, OVERFLOW=1, WORD_CNT=2.
//    -> Then OUT_READY=1: 16'h4321 pops, then 16'h8765, then OUT_VALID=0.
//  3 Full push+pop: queue full, and OUT_READY=1 on the same edge that completes 16'h0FED.
//    -> push accepted, OVERFLOW stays 0, WORD_CNT increments, pop order is preserved.
//  4 EN drop mid-word: 2 symbols sampled, then EN=0 for 3 cycles, then EN=1 with DIN=5,6,7,8.
//    -> the only word produced is 16'h8765.
//  5 Async reset mid-op: assert RST between clock edges with 1 word queued and lane=2.
//    -> OUT_VALID, DOUT, OVERFLOW and WORD_CNT are 0 immediately.
//    -> Next stream 1,2,3,4 yields 16'h4321.
//  6 WORD_CNT wrap: push 256 words with OUT_READY=1.
//    -> WORD_CNT reads 0, and no OVERFLOW.

Source files
------------

// File: rtl/symbol_packer_if.sv
// symbol_packer_if: stream-in / word-out bundle for symbol_packer.
//   en        - stream enable shared with the upstream decoder
//   din       - symbol presented by the decoder (DW bits)
//   out_ready - consumer accepts the head word this cycle
//   out_valid - output queue non-empty
//   dout      - head word (DW*PACK bits), 0 while the queue is empty
//   overflow  - sticky: a completed word was dropped on a full queue
//   word_cnt  - number of words accepted into the queue, wraps 255->0
// The packer uses the slave modport; the stream source/consumer uses master.
interface symbol_packer_if #(
  parameter int DW   = 4,
  parameter int PACK = 4
);
  logic                 en;
  logic [DW-1:0]        din;
  logic                 out_ready;
  logic                 out_valid;
  logic [DW*PACK-1:0]   dout;
  logic                 overflow;
  logic [7:0]           word_cnt;

  modport master (
    output en, din, out_ready,
    input  out_valid, dout, overflow, word_cnt
  );

  modport slave (
    input  en, din, out_ready,
    output out_valid, dout, overflow, word_cnt
  );
endinterface

// File: rtl/symbol_packer.sv
// symbol_packer: samples each decoder symbol once (the decoder holds every
// symbol for REP enabled cycles), packs PACK consecutive symbols LSB-lane
// first into one word, and queues finished words in a DEPTH-entry FIFO with
// a valid/ready output. A word completed while the queue is full and not
// popping is dropped and sets the sticky overflow flag.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous reset, active-high
//   bus - symbol_packer_if.slave (en, din, out_ready in; out_valid, dout,
//         overflow, word_cnt out)
module symbol_packer #(
  parameter int DW    = 4,
  parameter int PACK  = 4,
  parameter int REP   = 2,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  symbol_packer_if.slave  bus
);
  localparam int WW = DW * PACK;
  localparam int PW = (REP  > 1) ? $clog2(REP)  : 1;
  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW = $clog2(DEPTH);

  localparam logic [PW-1:0] PHASE_LAST = PW'(REP - 1);
  localparam logic [LW-1:0] LANE_LAST  = LW'(PACK - 1);

  logic [PW-1:0] phase;
  logic [LW-1:0] lane;
  logic [WW-1:0] partial;
  logic [WW-1:0] word_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   rd;
  logic [AW:0]   wr;
  logic [WW-1:0] mem [DEPTH];

  logic sample, push, pop, empty, full, push_ok;

  // The last enabled cycle of each held symbol is the one that samples it.
  assign sample  = bus.en && (phase == PHASE_LAST);
  assign push    = sample && (lane == LANE_LAST);
  assign empty   = (rd == wr);
  assign full    = (rd[AW-1:0] == wr[AW-1:0]) && (rd[AW] != wr[AW]);
  assign pop     = !empty && bus.out_ready;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok = push && (!full || pop);

  // Insert the current symbol into its lane; on the last lane this is the
  // completed word, since the upper lanes of partial are still zero.
  always_comb begin
    // NOTE: assign a full default before the partial overwrite so every bit is
    // driven on every path and no latch is inferred.
    word_next = partial;
    word_next[lane*DW +: DW] = bus.din;
  end

  // Symbol sampling and packing. Dropping en discards any incomplete word.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      lane    <= '0;
      partial <= '0;
    end else if (!bus.en) begin
      phase   <= '0;
      lane    <= '0;
      partial <= '0;
    end else begin
      phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
      if (sample) begin
        if (lane == LANE_LAST) begin
          lane    <= '0;
          partial <= '0;
        end else begin
          lane    <= lane + 1'b1;
          partial <= word_next;
        end
      end
    end
  end

  // Queue pointers, word counter and sticky overflow. These keep running
  // while en is low so the consumer can still drain the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd           <= '0;
      wr           <= '0;
      bus.word_cnt <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (pop)     rd <= rd + 1'b1;
      if (push_ok) begin
        wr           <= wr + 1'b1;
        bus.word_cnt <= bus.word_cnt + 8'd1;
      end
      if (push && !push_ok) bus.overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are valid and dout is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr[AW-1:0]] <= word_next;
  end

  assign bus.out_valid = !empty;
  assign bus.dout      = empty ? '0 : mem[rd[AW-1:0]];
endmodule
